// File: rtl/counter_updown_mod.sv
// Modulo-(MAX_VAL+1) up/down counter with wrap or saturate mode, clamped load,
// and registered carry/borrow pulses for cascading counter chains.
module counter_updown_mod #(
  parameter int N       = 6,
  parameter int MAX_VAL = 59
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic [N-1:0] cmp,
  output logic [N-1:0] q,
  output logic         carry,
  output logic         borrow,
  output logic         at_max,
  output logic         at_zero,
  output logic         match
);

  generate
    if ((N < 1) || (N > 31) || (MAX_VAL < 0) || (MAX_VAL > ((1 << N) - 1))) begin : g_bad_param
      $error("counter_updown_mod: MAX_VAL must lie in 0..2^N-1");
    end
  endgenerate

  // Next-state math is done one bit wider so 2^N-1 + 1 cannot alias to 0.
  localparam logic [N:0] MAX_W = MAX_VAL[N:0];
  localparam logic [N:0] ONE_W = {{N{1'b0}}, 1'b1};

  logic [N-1:0] count_q, count_d;
  logic         carry_q, carry_d;
  logic         borrow_q, borrow_d;

  logic [N:0] count_ext;
  logic [N:0] d_ext;
  logic [N:0] inc_ext;
  logic [N:0] dec_ext;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    count_d   = count_q;
    carry_d   = 1'b0;
    borrow_d  = 1'b0;
    count_ext = {1'b0, count_q};
    d_ext     = {1'b0, d};
    inc_ext   = count_ext + ONE_W;
    dec_ext   = count_ext - ONE_W;

    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (d_ext > MAX_W) ? MAX_W[N-1:0] : d;
    end else if (en) begin
      if (up) begin
        if (count_ext >= MAX_W) begin
          if (!sat) begin
            count_d = '0;
            carry_d = 1'b1;
          end
        end else begin
          count_d = inc_ext[N-1:0];
        end
      end else begin
        if (count_q == '0) begin
          if (!sat) begin
            count_d  = MAX_W[N-1:0];
            borrow_d = 1'b1;
          end
        end else begin
          count_d = dec_ext[N-1:0];
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together on the edge; the combinational block above uses blocking ones.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_q  <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
    end
  end

  assign q       = count_q;
  assign carry   = carry_q;
  assign borrow  = borrow_q;
  assign at_max  = ({1'b0, count_q} == MAX_W);
  assign at_zero = (count_q == '0);
  assign match   = (count_q == cmp);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: default 6-bit/59 instance plus
// 4-bit/15 and 4-bit/0 instances for the boundary configurations.
module tb_counter_updown_mod;

  logic       clk;
  logic       arst_n;
  logic       en, up, sat, clr, load;
  logic [5:0] d, cmp, q;
  logic       carry, borrow, at_max, at_zero, match;

  logic       en_b, up_b, sat_b, clr_b, load_b;
  logic [3:0] d_b, cmp_b, q_b, q_c;
  logic       carry_b, borrow_b, at_max_b, at_zero_b, match_b;
  logic       carry_c, borrow_c, at_max_c, at_zero_c, match_c;

  int errors = 0;
  int checks = 0;

  counter_updown_mod #(.N(6), .MAX_VAL(59)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .up(up), .sat(sat), .clr(clr),
    .load(load), .d(d), .cmp(cmp), .q(q), .carry(carry), .borrow(borrow),
    .at_max(at_max), .at_zero(at_zero), .match(match)
  );

  counter_updown_mod #(.N(4), .MAX_VAL(15)) dut_b (
    .clk(clk), .arst_n(arst_n), .en(en_b), .up(up_b), .sat(sat_b), .clr(clr_b),
    .load(load_b), .d(d_b), .cmp(cmp_b), .q(q_b), .carry(carry_b), .borrow(borrow_b),
    .at_max(at_max_b), .at_zero(at_zero_b), .match(match_b)
  );

  counter_updown_mod #(.N(4), .MAX_VAL(0)) dut_c (
    .clk(clk), .arst_n(arst_n), .en(en_b), .up(up_b), .sat(sat_b), .clr(clr_b),
    .load(load_b), .d(d_b), .cmp(cmp_b), .q(q_c), .carry(carry_c), .borrow(borrow_c),
    .at_max(at_max_c), .at_zero(at_zero_c), .match(match_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (q !== 6'd0) begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
    checks++;
    if ({carry, borrow} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {carry, borrow}); end
    checks++;
    if ({at_zero, at_max, match} !== 3'b101) begin errors++; $display("FAIL reset_flags: got %b expected 101", {at_zero, at_max, match}); end
    checks++;
    if ({at_zero_c, at_max_c, carry_c} !== 3'b110) begin errors++; $display("FAIL reset_max0_flags: got %b expected 110", {at_zero_c, at_max_c, carry_c}); end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    int pulses = 0;
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 59; i++) begin
      step();
      if (carry) pulses++;
    end
    checks++;
    if (q !== 6'd59 || at_max !== 1'b1) begin errors++; $display("FAIL up_to_max: got q=%0d at_max=%b expected q=59 at_max=1", q, at_max); end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL up_no_early_carry: got %0d pulses expected 0", pulses); end
    step();
    checks++;
    if (q !== 6'd0 || carry !== 1'b1 || at_zero !== 1'b1) begin errors++; $display("FAIL up_wrap: got q=%0d carry=%b at_zero=%b expected q=0 carry=1 at_zero=1", q, carry, at_zero); end
    step();
    checks++;
    if (q !== 6'd1 || carry !== 1'b0) begin errors++; $display("FAIL up_after_wrap: got q=%0d carry=%b expected q=1 carry=0", q, carry); end
  endtask

  task automatic test_down_wrap();
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (q !== 6'd0 || carry !== 1'b0) begin errors++; $display("FAIL clr: got q=%0d carry=%b expected q=0 carry=0", q, carry); end
    en = 1'b1; up = 1'b0;
    step();
    checks++;
    if (q !== 6'd59 || borrow !== 1'b1) begin errors++; $display("FAIL down_wrap: got q=%0d borrow=%b expected q=59 borrow=1", q, borrow); end
    step();
    checks++;
    if (q !== 6'd58 || borrow !== 1'b0) begin errors++; $display("FAIL down_after_wrap: got q=%0d borrow=%b expected q=58 borrow=0", q, borrow); end
  endtask

  task automatic test_saturate();
    int bad = 0;
    en = 1'b0; load = 1'b1; d = 6'd59;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (q !== 6'd59 || carry !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sat_high: got %0d bad cycles expected 0 (q=%0d)", bad, q); end
    bad = 0;
    clr = 1'b1;
    step();
    clr = 1'b0; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (q !== 6'd0 || borrow !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL sat_low: got %0d bad cycles expected 0 (q=%0d)", bad, q); end
    sat = 1'b0; en = 1'b0;
  endtask

  task automatic test_priority();
    load = 1'b1; d = 6'd63;
    step();
    checks++;
    if (q !== 6'd59 || carry !== 1'b0) begin errors++; $display("FAIL load_clamp: got q=%0d carry=%b expected q=59 carry=0", q, carry); end
    clr = 1'b1; d = 6'd10;
    step();
    checks++;
    if (q !== 6'd0) begin errors++; $display("FAIL clr_over_load: got %0d expected 0", q); end
    clr = 1'b0; en = 1'b1; up = 1'b1; d = 6'd20;
    step();
    checks++;
    if (q !== 6'd20) begin errors++; $display("FAIL load_over_en: got %0d expected 20", q); end
    load = 1'b0; en = 1'b0; cmp = 6'd20;
    #1;
    checks++;
    if (match !== 1'b1) begin errors++; $display("FAIL match_hit: got %b expected 1", match); end
    cmp = 6'd21;
    #1;
    checks++;
    if (match !== 1'b0) begin errors++; $display("FAIL match_miss: got %b expected 0", match); end
  endtask

  task automatic test_async_reset();
    load = 1'b1; d = 6'd58;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    checks++;
    if (q !== 6'd59) begin errors++; $display("FAIL pre_reset_q: got %0d expected 59", q); end
    step();
    // Counter just wrapped: carry is high mid-pulse when reset drops.
    #2;
    arst_n = 1'b0;
    #1;
    checks++;
    if (q !== 6'd0 || carry !== 1'b0) begin errors++; $display("FAIL async_reset: got q=%0d carry=%b expected q=0 carry=0", q, carry); end
    #1;
    arst_n = 1'b1;
    step();
    checks++;
    if (q !== 6'd1 || carry !== 1'b0) begin errors++; $display("FAIL resume_after_reset: got q=%0d carry=%b expected q=1 carry=0", q, carry); end
    en = 1'b0;
  endtask

  task automatic test_small_configs();
    int pulses = 0;
    int c_low = 0;
    en_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (carry_b) pulses++;
      if (carry_c !== 1'b1 || q_c !== 4'd0) c_low++;
    end
    checks++;
    if (q_b !== 4'd15 || at_max_b !== 1'b1) begin errors++; $display("FAIL n4_max: got q=%0d at_max=%b expected q=15 at_max=1", q_b, at_max_b); end
    step();
    if (carry_b) pulses++;
    if (carry_c !== 1'b1 || q_c !== 4'd0) c_low++;
    checks++;
    if (q_b !== 4'd0 || carry_b !== 1'b1) begin errors++; $display("FAIL n4_wrap: got q=%0d carry=%b expected q=0 carry=1", q_b, carry_b); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL n4_single_carry: got %0d pulses expected 1", pulses); end
    checks++;
    if (c_low !== 0) begin errors++; $display("FAIL max0_continuous_carry: got %0d bad cycles expected 0", c_low); end
    step();
    checks++;
    if (q_b !== 4'd1 || carry_b !== 1'b0) begin errors++; $display("FAIL n4_after_wrap: got q=%0d carry=%b expected q=1 carry=0", q_b, carry_b); end
    en_b = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    en = 1'b0; up = 1'b1; sat = 1'b0; clr = 1'b0; load = 1'b0; d = '0; cmp = '0;
    en_b = 1'b0; up_b = 1'b1; sat_b = 1'b0; clr_b = 1'b0; load_b = 1'b0; d_b = '0; cmp_b = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_async_reset();
    test_small_configs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
